// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx among N_REQ byte
// producers. A byte is accepted in ARB, the transmitter is started for one
// cycle in ISSUE, and WAIT holds until the transmitter reports completion or
// the watchdog gives up on it.
module uart_tx_arb #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 30000,
   localparam int OW     = $clog2(N_REQ),
   localparam int CW     = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic                 err,
   output logic [OW-1:0]        err_id,
   output logic                 busy,
   output logic [OW-1:0]        owner,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_done
);

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Last counter value allowed in WAIT before the transfer is abandoned.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [OW:0]   N_WIDE   = (OW + 1)'(N_REQ);

   state_t             state_r, state_n;
   logic [OW-1:0]      owner_r, owner_n;
   logic [OW-1:0]      last_r, last_n;
   logic [7:0]         data_r, data_n;
   logic [CW-1:0]      cnt_r, cnt_n;
   logic [OW-1:0]      err_id_r, err_id_n;
   logic [N_REQ-1:0]   done_r, done_n;
   logic               err_r, err_n;

   logic [OW-1:0]      win_s;
   logic               win_vld_s;

   // Round-robin pick: walk from last+N down to last+1 so the requester
   // closest after 'last' in cyclic order is the one that sticks.
   always_comb begin
      logic [OW:0] idx_v;
      logic [OW:0] wrap_v;
      win_s     = '0;
      win_vld_s = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx_v     = {1'b0, last_r} + (OW + 1)'(k);
         wrap_v    = (idx_v >= N_WIDE) ? (idx_v - N_WIDE) : idx_v;
         win_s     = req[wrap_v[OW-1:0]] ? wrap_v[OW-1:0] : win_s;
         win_vld_s = win_vld_s | req[wrap_v[OW-1:0]];
      end
   end

   // Next-state and next-register logic for the ARB/ISSUE/WAIT sequencer.
   always_comb begin
      state_n  = state_r;
      owner_n  = owner_r;
      last_n   = last_r;
      data_n   = data_r;
      cnt_n    = cnt_r;
      err_id_n = err_id_r;
      done_n   = '0;
      err_n    = 1'b0;
      case (state_r)
         ST_ARB: begin
            if (en && win_vld_s) begin
               owner_n = win_s;
               data_n  = req_data[{win_s, 3'b000} +: 8];
               state_n = ST_ISSUE;
            end else begin
               state_n = ST_ARB;
            end
         end
         ST_ISSUE: begin
            cnt_n   = '0;
            state_n = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            // Completion beats the watchdog when both land on the same cycle.
            if (tx_done) begin
               done_n[owner_r] = 1'b1;
               last_n          = owner_r;
               state_n         = ST_ARB;
            end else if (cnt_r == CNT_LAST) begin
               err_n    = 1'b1;
               err_id_n = owner_r;
               last_n   = owner_r;
               state_n  = ST_ARB;
            end else begin
               state_n = ST_WAIT;
            end
         end
         default: begin
            state_n = ST_ARB;
         end
      endcase
   end

   // State and datapath registers; last starts at N_REQ-1 so requester 0 leads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_ARB;
         owner_r  <= '0;
         last_r   <= OW'(N_REQ - 1);
         data_r   <= 8'h00;
         cnt_r    <= '0;
         err_id_r <= '0;
         done_r   <= '0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_n;
         owner_r  <= owner_n;
         last_r   <= last_n;
         data_r   <= data_n;
         cnt_r    <= cnt_n;
         err_id_r <= err_id_n;
         done_r   <= done_n;
         err_r    <= err_n;
      end
   end

   // Grant is decoded from the registered state and owner only.
   always_comb begin
      gnt = '0;
      if (state_r == ST_ISSUE) begin
         gnt[owner_r] = 1'b1;
      end else begin
         gnt = '0;
      end
   end

   assign tx_start = (state_r == ST_ISSUE);
   assign busy     = (state_r != ST_ARB);
   assign tx_data  = data_r;
   assign owner    = owner_r;
   assign done     = done_r;
   assign err      = err_r;
   assign err_id   = err_id_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a driver models the requesters and predicts every
// grant and completion (with its cycle) from the arbitration rules; a
// responder stands in for uart_tx; a monitor pops the expectations.
module tb_uart_tx_arb;
   localparam int N = 4;
   localparam int T = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        err;
   logic [1:0]  err_id;
   logic        busy;
   logic [1:0]  owner;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;

   uart_tx_arb #(.N_REQ(N), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
      .gnt(gnt), .done(done), .err(err), .err_id(err_id), .busy(busy),
      .owner(owner), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = grant, 1 = done, 2 = watchdog error
   typedef struct {
      int kind;
      int id;
      int data;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   dq[$];
   int   dues[$];
   int   n_chk = 0;
   int   n_fail = 0;

   logic [3:0] mask_v;
   logic [7:0] dat [4];
   int last_m, prev_comp, apply_c, en_c;

   task automatic check(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                  name, got, got, want, want, cyc);
      end
   endtask

   function automatic int max3(input int a, input int b, input int c);
      int m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // First requester with a pending byte after 'last', cyclically.
   function automatic int rr_pick(input int last, input logic [3:0] m);
      for (int k = 1; k <= N; k++) begin
         int i = (last + k) % N;
         if (m[i]) return i;
      end
      return -1;
   endfunction

   // Transmitter latency choice, weighted towards the watchdog boundaries.
   function automatic int rand_d();
      int r = int'($urandom_range(0, 9));
      case (r)
         0: return 0;
         1: return T;
         2: return T + 1;
         3: return T + 2;
         4: return 1;
         default: return int'($urandom_range(1, T));
      endcase
   endfunction

   task automatic drive();
      req      = mask_v;
      req_data = {dat[3], dat[2], dat[1], dat[0]};
   endtask

   task automatic raise(input logic [3:0] m);
      mask_v  = m;
      apply_c = cyc;
      drive();
   endtask

   // Predict one grant plus its completion; d = transmitter latency in cycles
   // after ISSUE (0 = never, -1 = transfer will be killed by reset).
   task automatic serve(input int d, input logic [3:0] add, input bit keep);
      int w, g;
      bit ok;
      if (mask_v == 4'd0) return;
      w = rr_pick(last_m, mask_v);
      g = max3(prev_comp + 1, apply_c + 1, en_c + 1);
      sb.push_back('{0, w, int'(dat[w]), g});
      dq.push_back((d > 0) ? d : 0);
      if (d >= 1 && d <= T) begin
         sb.push_back('{1, w, 0, g + d + 1});
         prev_comp = g + d + 1;
      end else if (d == 0 || d > T) begin
         sb.push_back('{2, w, 0, g + T + 1});
         prev_comp = g + T + 1;
      end else begin
         prev_comp = g;
      end
      last_m = w;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (gnt != 4'd0) begin
            ok = 1'b1;
            break;
         end
      end
      check("gnt_within_bound", int'(ok), 1);
      if (!ok) return;
      dat[w] = 8'($urandom_range(0, 255));
      if (!keep) mask_v[w] = 1'b0;
      mask_v  = mask_v | add;
      apply_c = cyc;
      drive();
   endtask

   task automatic idle_wait();
      bit ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (cyc >= prev_comp) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("idle_within_bound", int'(ok), 1);
   endtask

   task automatic check_reset_values();
      check("rst_gnt", int'(gnt), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_err_id", int'(err_id), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_owner", int'(owner), 0);
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_tx_data", int'(tx_data), 0);
   endtask

   // Transmitter stand-in: pulses tx_done a chosen number of cycles after start.
   initial begin : responder
      bit hit;
      int dd;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         hit = 1'b0;
         for (int k = 0; k < dues.size(); k++) begin
            if (dues[k] == cyc) begin
               hit = 1'b1;
               dues.delete(k);
               break;
            end
         end
         tx_done = hit;
         if (tx_start && !rst && dq.size() > 0) begin
            dd = dq.pop_front();
            if (dd > 0) dues.push_back(cyc + dd);
         end
      end
   end

   // Scoreboard monitor: every grant/done/err must match the queue head.
   initial begin : monitor
      exp_t e;
      int exp_err_id = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_err_id = 0;
         end else begin
            if (done != 4'd0 || err) begin
               if (sb.size() == 0 || sb[0].kind == 0) begin
                  check("unexpected_done", int'(done), 0);
                  check("unexpected_err", int'(err), 0);
               end else begin
                  e = sb.pop_front();
                  check("done_vec", int'(done), (e.kind == 1) ? (1 << e.id) : 0);
                  check("err_flag", int'(err), (e.kind == 2) ? 1 : 0);
                  if (e.kind == 2) begin
                     check("err_id", int'(err_id), e.id);
                     exp_err_id = e.id;
                  end
                  check("completion_cycle", cyc, e.cyc);
               end
            end
            if (gnt != 4'd0) begin
               if (sb.size() == 0 || sb[0].kind != 0) begin
                  check("unexpected_gnt", int'(gnt), 0);
               end else begin
                  e = sb.pop_front();
                  check("gnt_vec", int'(gnt), 1 << e.id);
                  check("tx_start_with_gnt", int'(tx_start), 1);
                  check("tx_data", int'(tx_data), e.data);
                  check("owner", int'(owner), e.id);
                  check("gnt_cycle", cyc, e.cyc);
                  check("err_id_hold", int'(err_id), exp_err_id);
               end
            end else if (tx_start) begin
               check("tx_start_without_gnt", int'(tx_start), 0);
            end
         end
      end
   end

   initial begin : stimulus
      bit ok;
      rst = 1'b1; en = 1'b1; req = 4'd0; req_data = 32'd0;
      mask_v = 4'd0;
      for (int i = 0; i < 4; i++) dat[i] = 8'h00;
      last_m = N - 1; prev_comp = -10; apply_c = -10; en_c = -10;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b0;

      // All four requesting continuously: order 0,1,2,3,0,...
      dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
      raise(4'b1111);
      repeat (8) serve(int'($urandom_range(1, 12)), 4'd0, 1'b1);
      while (mask_v != 4'd0) serve(int'($urandom_range(1, 12)), 4'd0, 1'b0);
      idle_wait();

      // Single byte from requester 2.
      dat[2] = 8'hA5;
      raise(4'b0100);
      serve(20, 4'd0, 1'b0);
      idle_wait();

      // Rotation around requesters 3 and 0.
      raise(4'b1000);
      serve(5, 4'd0, 1'b0);
      idle_wait();
      raise(4'b1001);
      serve(5, 4'b0001, 1'b0);
      while (mask_v != 4'd0) serve(5, 4'd0, 1'b0);
      idle_wait();

      // Enable low: request held off, then granted the cycle after en rises.
      en = 1'b0;
      raise(4'b0010);
      repeat (100) begin
         @(negedge clk);
         check("busy_while_disabled", int'(busy), 0);
      end
      en = 1'b1;
      en_c = cyc;
      serve(8, 4'd0, 1'b0);
      idle_wait();

      // Watchdog: never completes, completes on the last counter value, late.
      raise(4'b0010);
      serve(0, 4'd0, 1'b0);
      idle_wait();
      raise(4'b0010);
      serve(T, 4'd0, 1'b0);
      idle_wait();
      raise(4'b0100);
      serve(T + 1, 4'd0, 1'b0);
      idle_wait();

      // Randomised traffic.
      repeat (60) begin
         if (mask_v == 4'd0) begin
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            raise(4'($urandom_range(1, 15)));
         end
         serve(rand_d(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      while (mask_v != 4'd0) serve(rand_d(), 4'd0, 1'b0);
      idle_wait();

      // Reset in the middle of WAIT: in-flight byte is dropped silently.
      raise(4'b0100);
      serve(-1, 4'd0, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      last_m = N - 1; prev_comp = -10; en_c = -10;
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom_range(0, 255));
      raise(4'b1111);
      serve(6, 4'd0, 1'b0);
      while (mask_v != 4'd0) serve(int'($urandom_range(1, T)), 4'd0, 1'b0);
      idle_wait();

      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("scoreboard_drained", sb.size(), 0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
